lfsr_burst_scheduler: RTL and testbench

- Sequences an external LFSR instance (enable / seed-load / data interface) as a test-pattern source for the lock-in datapath.
- Loads a seed, advances the LFSR once per programmed decimation interval, and emits one sample per step on a valid/ready stream.
- Runs bursts of programmable length or continuous mode; stalls the LFSR under backpressure so no step is lost.
- Sits between the data_source LFSR and the downstream sample consumer.

---
 rtl/lfsr_burst_scheduler.sv | 139 +++++++++++++
 tb/tb_lfsr_burst_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_scheduler.sv
// Sequences an external XNOR LFSR as a decimated, backpressure-aware sample source.
// Optional: define LFSR_SEED_CONTINUE_EN to let a start with seed 0 continue the running sequence.
module lfsr_burst_scheduler #(
    parameter int NUM_BITS = 8,
    parameter int LEN_W    = 16,
    parameter int DECIM_W  = 8
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    input  logic                i_Abort,
    input  logic [NUM_BITS-1:0] i_Seed,
    input  logic [LEN_W-1:0]    i_Burst_Len,
    input  logic [DECIM_W-1:0]  i_Decim,
    output logic                o_Lfsr_Enable,
    output logic                o_Lfsr_Seed_DV,
    output logic [NUM_BITS-1:0] o_Lfsr_Seed_Data,
    input  logic [NUM_BITS-1:0] i_Lfsr_Data,
    output logic [NUM_BITS-1:0] o_Data,
    output logic                o_Valid,
    input  logic                i_Ready,
    output logic                o_Busy,
    output logic                o_Done,
    output logic [LEN_W-1:0]    o_Sample_Count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [NUM_BITS-1:0] r_seed;
    logic [LEN_W-1:0]    r_len;
    logic [DECIM_W-1:0]  r_decim;
    logic [DECIM_W-1:0]  r_decim_cnt;
    logic [LEN_W-1:0]    r_count;
    logic [NUM_BITS-1:0] r_data;
    logic                r_valid;

    logic [2:0]          w_state_next;
    logic                w_slot_free;
    logic                w_capture;
    logic                w_last;
    logic                w_start_ok;
    logic                w_skip_seed;
    logic [LEN_W-1:0]    w_count_next;
    logic [NUM_BITS-1:0] w_seed_latch;

    assign w_slot_free  = !r_valid || i_Ready;
    assign w_capture    = (r_state == S_RUN) && (r_decim_cnt == r_decim) && w_slot_free && !i_Abort;
    assign w_count_next = r_count + LEN_W'(1);
    assign w_last       = (r_len != '0) && (w_count_next == r_len);
    assign w_start_ok   = (r_state == S_IDLE) && i_Start && !i_Abort;
    // All-ones is the XNOR lock-up state, so it is never handed to the LFSR.
    assign w_seed_latch = (i_Seed == '1) ? '0 : i_Seed;

`ifdef LFSR_SEED_CONTINUE_EN
    logic r_seeded;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            r_seeded <= 1'b0;
        else if (w_start_ok)
            r_seeded <= 1'b1;
    end

    assign w_skip_seed = r_seeded && (i_Seed == '0);
`else
    assign w_skip_seed = 1'b0;
`endif

    // NOTE: default assignment first so every path drives w_state_next (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_next = w_skip_seed ? S_RUN : S_SEED;
            S_SEED:  w_state_next = S_RUN;
            S_RUN:   if (w_capture && w_last) w_state_next = S_DRAIN;
            S_DRAIN: if (w_slot_free) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (i_Abort)
            w_state_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state     <= S_IDLE;
            r_seed      <= '0;
            r_len       <= '0;
            r_decim     <= '0;
            r_decim_cnt <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_start_ok) begin
                r_len       <= i_Burst_Len;
                r_decim     <= i_Decim;
                r_decim_cnt <= '0;
                r_count     <= '0;
                if (!w_skip_seed)
                    r_seed <= w_seed_latch;
            end else if ((r_state == S_RUN) && !i_Abort) begin
                if (w_capture) begin
                    r_decim_cnt <= '0;
                    r_count     <= w_count_next;
                end else if (r_decim_cnt != r_decim) begin
                    r_decim_cnt <= r_decim_cnt + DECIM_W'(1);
                end
            end

            // A capture reloads the slot in the same cycle the old sample is accepted.
            if (i_Abort)
                r_valid <= 1'b0;
            else if (w_capture) begin
                r_valid <= 1'b1;
                r_data  <= i_Lfsr_Data;
            end else if (r_valid && i_Ready)
                r_valid <= 1'b0;
        end
    end

    assign o_Lfsr_Enable    = (r_state == S_SEED) || w_capture;
    assign o_Lfsr_Seed_DV   = (r_state == S_SEED);
    assign o_Lfsr_Seed_Data = r_seed;
    assign o_Data           = r_data;
    assign o_Valid          = r_valid;
    assign o_Busy           = (r_state == S_SEED) || (r_state == S_RUN);
    assign o_Done           = (r_state == S_DONE) && !i_Abort;
    assign o_Sample_Count   = r_count;

endmodule

// File: tb/tb_lfsr_burst_scheduler.sv
// Directed bench for lfsr_burst_scheduler driving an 8-bit XNOR LFSR (taps 8,6,5,4).
// Covers LFSR_SEED_CONTINUE_EN behaviour when that macro is defined.
module tb_lfsr_burst_scheduler;

    logic        clk;
    logic        rst_n;
    logic        i_Start;
    logic        i_Abort;
    logic [7:0]  i_Seed;
    logic [15:0] i_Burst_Len;
    logic [7:0]  i_Decim;
    logic        o_Lfsr_Enable;
    logic        o_Lfsr_Seed_DV;
    logic [7:0]  o_Lfsr_Seed_Data;
    logic [7:0]  lfsr_q;
    logic [7:0]  o_Data;
    logic        o_Valid;
    logic        i_Ready;
    logic        o_Busy;
    logic        o_Done;
    logic [15:0] o_Sample_Count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_seq [0:5];

    lfsr_burst_scheduler dut (
        .i_Clk            (clk),
        .i_Rst_n          (rst_n),
        .i_Start          (i_Start),
        .i_Abort          (i_Abort),
        .i_Seed           (i_Seed),
        .i_Burst_Len      (i_Burst_Len),
        .i_Decim          (i_Decim),
        .o_Lfsr_Enable    (o_Lfsr_Enable),
        .o_Lfsr_Seed_DV   (o_Lfsr_Seed_DV),
        .o_Lfsr_Seed_Data (o_Lfsr_Seed_Data),
        .i_Lfsr_Data      (lfsr_q),
        .o_Data           (o_Data),
        .o_Valid          (o_Valid),
        .i_Ready          (i_Ready),
        .o_Busy           (o_Busy),
        .o_Done           (o_Done),
        .o_Sample_Count   (o_Sample_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External LFSR: seed load on enable+seed_dv, otherwise XNOR shift on enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= 8'h00;
        else if (o_Lfsr_Enable) begin
            if (o_Lfsr_Seed_DV)
                lfsr_q <= o_Lfsr_Seed_Data;
            else
                lfsr_q <= {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3])};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        exp_seq[0] = 8'h00; exp_seq[1] = 8'h01; exp_seq[2] = 8'h03;
        exp_seq[3] = 8'h07; exp_seq[4] = 8'h0F; exp_seq[5] = 8'h1E;

        rst_n = 1'b0; i_Start = 1'b0; i_Abort = 1'b0; i_Seed = 8'h00;
        i_Burst_Len = 16'd0; i_Decim = 8'd0; i_Ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o_Valid, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_done", o_Done, 0);
        check("rst_count", o_Sample_Count, 0);
        check("rst_data", o_Data, 0);
        check("rst_seed_data", o_Lfsr_Seed_Data, 0);
        check("rst_enable", o_Lfsr_Enable, 0);
        check("rst_seed_dv", o_Lfsr_Seed_DV, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Burst of 6, D=0, ready high: one sample per clock.
        i_Start = 1'b1; i_Seed = 8'h00; i_Burst_Len = 16'd6; i_Decim = 8'd0; i_Ready = 1'b1;
        tick();
        i_Start = 1'b0;
        check("t1_seed_dv", o_Lfsr_Seed_DV, 1);
        check("t1_seed_en", o_Lfsr_Enable, 1);
        check("t1_seed_busy", o_Busy, 1);
        tick();
        check("t1_run_valid0", o_Valid, 0);
        check("t1_run_en", o_Lfsr_Enable, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t1_valid", o_Valid, 1);
            check("t1_data", o_Data, exp_seq[k]);
        end
        tick();
        check("t1_done", o_Done, 1);
        check("t1_count", o_Sample_Count, 6);
        check("t1_done_valid", o_Valid, 0);
        check("t1_done_busy", o_Busy, 0);
        tick();
        check("t1_done_pulse", o_Done, 0);

        // D=3: first valid 5 clocks after start, then spaced 4 clocks.
        i_Start = 1'b1; i_Seed = 8'hFF; i_Burst_Len = 16'd6; i_Decim = 8'd3;
        tick();
        i_Start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t2_lat_valid0", o_Valid, 0);
        end
        tick();
        check("t2_first_valid", o_Valid, 1);
        check("t2_first_data", o_Data, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t2_gap_valid0", o_Valid, 0);
        end
        tick();
        check("t2_second_valid", o_Valid, 1);
        check("t2_second_data", o_Data, 8'h01);
        n = 0;
        while (!o_Done && n < 100) begin
            tick();
            n++;
        end
        check("t2_done_seen", o_Done, 1);
        check("t2_count", o_Sample_Count, 6);
        tick();

        // Backpressure: ready low 10 cycles after first valid.
        i_Start = 1'b1; i_Seed = 8'hFF; i_Burst_Len = 16'd6; i_Decim = 8'd0; i_Ready = 1'b0;
        tick();
        i_Start = 1'b0;
        tick();
        tick();
        check("t3_first_valid", o_Valid, 1);
        check("t3_first_data", o_Data, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_data", o_Data, 8'h00);
            check("t3_hold_valid", o_Valid, 1);
            check("t3_hold_en", o_Lfsr_Enable, 0);
        end
        i_Ready = 1'b1;
        #1;
        check("t3_resume_en", o_Lfsr_Enable, 1);
        for (int k = 1; k < 6; k++) begin
            tick();
            check("t3_resume_data", o_Data, exp_seq[k]);
        end
        tick();
        check("t3_done", o_Done, 1);
        tick();

        // Plain seed is passed through; all-ones seed becomes 0.
        i_Start = 1'b1; i_Seed = 8'h5A; i_Burst_Len = 16'd1; i_Decim = 8'd0;
        tick();
        i_Start = 1'b0;
        check("t4_seed_5a", o_Lfsr_Seed_Data, 8'h5A);
        tick();
        tick();
        check("t4_data_5a", o_Data, 8'h5A);
        tick();
        check("t4_done_5a", o_Done, 1);
        tick();
        i_Start = 1'b1; i_Seed = 8'hFF;
        tick();
        i_Start = 1'b0;
        check("t4_seed_ff", o_Lfsr_Seed_Data, 8'h00);
        tick();
        tick();
        check("t4_data_ff", o_Data, 8'h00);
        tick();
        check("t4_done_ff", o_Done, 1);
        tick();

        // Continuous mode, start during RUN ignored, abort after 20 samples.
        i_Start = 1'b1; i_Seed = 8'hFF; i_Burst_Len = 16'd0; i_Decim = 8'd0;
        tick();
        i_Start = 1'b0;
        tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) begin
                i_Start = 1'b1; i_Seed = 8'h33; i_Burst_Len = 16'd3;
            end
            if (i == 11) begin
                i_Start = 1'b0;
                check("t5_no_reseed_dv", o_Lfsr_Seed_DV, 0);
                check("t5_busy_run", o_Busy, 1);
            end
        end
        check("t5_count20", o_Sample_Count, 20);
        check("t5_still_busy", o_Busy, 1);
        check("t5_seed_kept", o_Lfsr_Seed_Data, 8'h00);
        i_Abort = 1'b1;
        #1;
        check("t5_abort_en", o_Lfsr_Enable, 0);
        tick();
        i_Abort = 1'b0;
        check("t5_abort_valid", o_Valid, 0);
        check("t5_abort_busy", o_Busy, 0);
        check("t5_abort_done", o_Done, 0);
        check("t5_abort_count", o_Sample_Count, 20);
        tick();
        check("t5_no_done", o_Done, 0);

        // Start and abort together in IDLE: abort wins.
        i_Start = 1'b1; i_Abort = 1'b1; i_Seed = 8'h5A;
        tick();
        i_Start = 1'b0; i_Abort = 1'b0;
        check("t6_busy", o_Busy, 0);
        check("t6_seed_dv", o_Lfsr_Seed_DV, 0);
        check("t6_seed_data", o_Lfsr_Seed_Data, 8'h00);
        tick();
        check("t6_busy_later", o_Busy, 0);

`ifdef LFSR_SEED_CONTINUE_EN
        // Burst 3 from 0, then a seed-0 start continues with 07,0F,1E.
        i_Start = 1'b1; i_Seed = 8'hFF; i_Burst_Len = 16'd3; i_Decim = 8'd0; i_Ready = 1'b1;
        tick();
        i_Start = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t7_first_data", o_Data, exp_seq[k]);
        end
        tick();
        check("t7_first_done", o_Done, 1);
        tick();
        i_Start = 1'b1; i_Seed = 8'h00;
        tick();
        i_Start = 1'b0;
        check("t7_no_seed_dv", o_Lfsr_Seed_DV, 0);
        check("t7_busy", o_Busy, 1);
        for (int k = 3; k < 6; k++) begin
            tick();
            check("t7_cont_data", o_Data, exp_seq[k]);
        end
        tick();
        check("t7_cont_done", o_Done, 1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
